// File: rtl/cal_ctrl.sv
// rtl/cal_ctrl.sv - ASCII calculator sequencer: parses "<decA><op><decB>=" and emits hex result + CR LF
module cal_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    localparam int NDIG = WIDTH / 4;
    localparam int IW   = $clog2(NDIG + 2);

    typedef enum logic [2:0] {S_OPA, S_OPB, S_CALC, S_SEND, S_ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d, err_q, err_d;

    logic             is_digit, is_op, is_eq, is_space;
    op_t              rx_op;
    logic [WIDTH-1:0] digit, opa_acc, opb_acc;
    logic [IW-1:0]    last_idx;
    logic [3:0]       nib;
    logic [7:0]       hex_char;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A);
    assign is_eq    = (rx_data == 8'h3D);
    assign is_space = (rx_data == 8'h20);
    assign rx_op    = (rx_data == 8'h2D) ? OP_SUB : (rx_data == 8'h2A) ? OP_MUL : OP_ADD;
    assign digit    = {{(WIDTH-4){1'b0}}, rx_data[3:0]};

    // x*10 = x*8 + x*2, truncated to WIDTH
    assign opa_acc  = {opa_q[WIDTH-4:0], 3'b000} + {opa_q[WIDTH-2:0], 1'b0} + digit;
    assign opb_acc  = {opb_q[WIDTH-4:0], 3'b000} + {opb_q[WIDTH-2:0], 1'b0} + digit;

    assign last_idx = (state_q == S_ERR) ? IW'(2) : IW'(NDIG + 1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_OPA;
            op_q     <= OP_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_OPA: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        opa_d = opa_acc;
                    end else if (is_op) begin
                        op_d    = rx_op;
                        state_d = S_OPB;
                    end else if (!is_space) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = S_ERR;
                    end
                end
            end
            S_OPB: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        opb_d = opb_acc;
                    end else if (is_eq) begin
                        state_d = S_CALC;
                    end else if (!is_space) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = S_ERR;
                    end
                end
            end
            S_CALC: begin
                case (op_q)
                    OP_SUB:  result_d = opa_q - opb_q;
                    OP_MUL:  result_d = opa_q * opb_q;
                    default: result_d = opa_q + opb_q;
                endcase
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND, S_ERR: begin
                if (tx_ready) begin
                    if (idx_q == last_idx) begin
                        opa_d   = '0;
                        opb_d   = '0;
                        idx_d   = '0;
                        state_d = S_OPA;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_OPA;
        endcase
    end

    // Result nibble selected by idx, most significant first
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) nib = result_q[(NDIG-1-i)*4 +: 4];
        end
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_SEND: begin
                tx_valid = 1'b1;
                if (idx_q < IW'(NDIG))       tx_data = hex_char;
                else if (idx_q == IW'(NDIG)) tx_data = 8'h0D;
                else                         tx_data = 8'h0A;
            end
            S_ERR: begin
                tx_valid = 1'b1;
                if (idx_q == IW'(0))      tx_data = 8'h45;
                else if (idx_q == IW'(1)) tx_data = 8'h0D;
                else                      tx_data = 8'h0A;
            end
            default: ;
        endcase
    end

    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// tb/tb_cal_ctrl.sv - directed table-driven bench for cal_ctrl
module tb_cal_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] result;
    logic        done;
    logic        err;

    cal_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .result   (result),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       expr;
        logic [15:0] exp_result;
        bit          exp_err;
        string       exp_hex;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] txq[$];
    int         done_cnt;
    int         err_cnt;
    int         n_vec;
    int         n_miss;

    // Inputs change at posedge+2; the monitor samples at negedge
    always @(negedge clk) begin
        if (n_rst) begin
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    function automatic vec_t mk(string e, logic [15:0] r, bit er, string h);
        vec_t v;
        v.expr = e; v.exp_result = r; v.exp_err = er; v.exp_hex = h;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(string s);
        for (int k = 0; k < s.len(); k++) send_byte(8'(s[k]));
    endtask

    task automatic wait_frame(int len);
        int n = 0;
        while (txq.size() < len && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        if (txq.size() < len) check("frame_timeout", 32'(txq.size()), 32'(len));
        repeat (2) begin @(posedge clk); #2; end
    endtask

    task automatic check_frame(string tag, string hex);
        int len = hex.len() + 2;
        logic [7:0] e;
        check({tag, "_len"}, 32'(txq.size()), 32'(len));
        for (int k = 0; k < len; k++) begin
            if (k < hex.len())           e = 8'(hex[k]);
            else if (k == hex.len())     e = 8'h0D;
            else                         e = 8'h0A;
            if (k < txq.size()) check({tag, "_byte"}, 32'(txq[k]), 32'(e));
        end
    endtask

    task automatic clear_mon();
        txq.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("tx_valid_wait", 32'(tx_valid), 32'd1);
    endtask

    initial begin
        logic [7:0] held;
        int         unstable;

        n_vec = 0; n_miss = 0;
        done_cnt = 0; err_cnt = 0;
        n_rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;

        vecs.push_back(mk("12+34=",   16'h002E, 1'b0, "002E"));
        vecs.push_back(mk("5-7=",     16'hFFFE, 1'b0, "FFFE"));
        vecs.push_back(mk("300*300=", 16'h5F90, 1'b0, "5F90"));
        vecs.push_back(mk("1=",       16'h5F90, 1'b1, "E"));
        vecs.push_back(mk("2+2=",     16'h0004, 1'b0, "0004"));
        vecs.push_back(mk("+5=",      16'h0005, 1'b0, "0005"));
        vecs.push_back(mk(" 7 * 8 =", 16'h0038, 1'b0, "0038"));
        vecs.push_back(mk("1+x",      16'h0038, 1'b1, "E"));
        vecs.push_back(mk("65535+1=", 16'h0000, 1'b0, "0000"));
        vecs.push_back(mk("70000+0=", 16'h1170, 1'b0, "1170"));
        vecs.push_back(mk("1+2-3=",   16'h1170, 1'b1, "E"));
        vecs.push_back(mk("=",        16'h1170, 1'b1, "E"));
        vecs.push_back(mk("9*9=",     16'h0051, 1'b0, "0051"));

        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_result",   32'(result),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        n_rst = 1'b1;
        @(posedge clk); #2;

        foreach (vecs[i]) begin
            clear_mon();
            send_str(vecs[i].expr);
            wait_frame(vecs[i].exp_hex.len() + 2);
            check("result", 32'(result), 32'(vecs[i].exp_result));
            check("done_cnt", 32'(done_cnt), vecs[i].exp_err ? 32'd0 : 32'd1);
            check("err_cnt",  32'(err_cnt),  vecs[i].exp_err ? 32'd1 : 32'd0);
            check_frame("tx", vecs[i].exp_hex);
            check("idle_tx_valid", 32'(tx_valid), 32'd0);
        end

        // '=' strobe at t: S_CALC at t+1, done and first tx_valid at t+2
        clear_mon();
        send_str("2+3");
        rx_data = 8'h3D; rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
        check("lat_calc_done",  32'(done),     32'd0);
        check("lat_calc_valid", 32'(tx_valid), 32'd0);
        @(posedge clk); #2;
        check("lat_done",       32'(done),     32'd1);
        check("lat_valid",      32'(tx_valid), 32'd1);
        check("lat_first_byte", 32'(tx_data),  32'h30);
        wait_frame(6);
        check("lat_result", 32'(result), 32'h0005);
        check_frame("lat", "0005");

        // Mid-frame stall with bytes arriving during S_SEND
        clear_mon();
        tx_ready = 1'b0;
        send_str("4660+0=");
        wait_tx_valid();
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tx_ready = 1'b0;
        held = tx_data;
        check("stall_byte", 32'(held), 32'h33);
        unstable = 0;
        send_str("9*9=");
        for (int c = 0; c < 16; c++) begin
            if (tx_data !== held || tx_valid !== 1'b1) unstable++;
            @(posedge clk); #2;
        end
        check("stall_stable", 32'(unstable), 32'd0);
        tx_ready = 1'b1;
        wait_frame(6);
        check("stall_result", 32'(result), 32'h1234);
        check("stall_done",   32'(done_cnt), 32'd1);
        check_frame("stall", "1234");
        clear_mon();
        send_str("2*3=");
        wait_frame(6);
        check("post_stall_result", 32'(result), 32'h0006);
        check_frame("post_stall", "0006");

        // Asynchronous reset while sending byte idx 2
        clear_mon();
        tx_ready = 1'b0;
        send_str("12+34=");
        wait_tx_valid();
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tx_ready = 1'b0;
        n_rst = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_tx_data",  32'(tx_data),  32'd0);
        check("arst_result",   32'(result),   32'd0);
        check("arst_done",     32'(done),     32'd0);
        check("arst_err",      32'(err),      32'd0);
        @(posedge clk); #2;
        n_rst = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #2;
        clear_mon();
        send_str("1+1=");
        wait_frame(6);
        check("arst_next_result", 32'(result), 32'h0002);
        check("arst_next_done",   32'(done_cnt), 32'd1);
        check_frame("arst_next", "0002");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
